// File: rtl/dds_pkg.sv
// Shared definitions for the DDS sweep controller: datapath widths,
// sweep FSM encoding and sweep-mode constants.
package dds_pkg;

  localparam int KW = 32;  // tuning-word width, matches DDS K
  localparam int PW = 11;  // phase-offset width, matches DDS P
  localparam int DW = 16;  // dwell-counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2
  } state_t;

  localparam logic MODE_SINGLE = 1'b0;
  localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Config/control and DDS-core bus of the sweep controller.
//
// Handshake: start and abort are one-cycle requests with no ready; start is
// accepted only in IDLE and dropped otherwise. upd acts as the valid strobe
// for k_out/p_out (high only in the first cycle a value is presented); the
// DDS core always accepts, so there is no ready. done is a one-cycle pulse
// and never coincides with upd.
interface dds_sweep_ctrl_if;
  import dds_pkg::*;

  logic            start;
  logic            abort;
  logic            cfg_mode;
  logic [KW-1:0]   cfg_k_start;
  logic [KW-1:0]   cfg_k_stop;
  logic [KW-1:0]   cfg_k_step;
  logic [DW-1:0]   cfg_dwell;
  logic [PW-1:0]   cfg_phase;
  logic [KW-1:0]   k_out;
  logic [PW-1:0]   p_out;
  logic            upd;
  logic            busy;
  logic            done;
  state_t          dbg_state;

  // Register/config side: issues requests, observes the DDS outputs.
  modport master (
    output start, abort, cfg_mode, cfg_k_start, cfg_k_stop, cfg_k_step,
           cfg_dwell, cfg_phase,
    input  k_out, p_out, upd, busy, done, dbg_state
  );

  // Sweep controller side.
  modport slave (
    input  start, abort, cfg_mode, cfg_k_start, cfg_k_stop, cfg_k_step,
           cfg_dwell, cfg_phase,
    output k_out, p_out, upd, busy, done, dbg_state
  );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter that measures how long each tuning word is held.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int W = DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; the counter parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep scheduler driving the DDS tuning word and phase.
// Config is captured once at start; each K is held dwell+2 cycles
// (dwell+1 in DWELL plus one STEP cycle).
module dds_sweep_ctrl
  import dds_pkg::*;
(
  input  logic clk,
  input  logic rst,
  dds_sweep_ctrl_if.slave bus
);

  state_t        state, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] p_q, p_d;
  logic          upd_q, upd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          sh_mode;
  logic [KW-1:0] sh_start, sh_stop, sh_step;
  logic [DW-1:0] sh_dwell;
  logic          sh_load;

  logic          tmr_load, tmr_dec, tmr_zero;
  logic [DW-1:0] tmr_val;

  // Carry is kept so a step past the top of the K range ends the sweep
  // instead of wrapping to a small tuning word.
  logic [KW:0]   step_sum;
  logic          step_ok;

  assign step_sum = {1'b0, k_q} + {1'b0, sh_step};
  assign step_ok  = !step_sum[KW] && (step_sum[KW-1:0] <= sh_stop) &&
                    (sh_step != '0);

  dds_dwell_timer #(.W(DW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state logic; abort dominates in every state.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (bus.start && !bus.abort) state_d = DWELL;
      DWELL: if (bus.abort)               state_d = IDLE;
             else if (tmr_zero)           state_d = STEP;
      STEP:  if (bus.abort)               state_d = IDLE;
             else if (step_ok || sh_mode == MODE_CONT) state_d = DWELL;
             else                         state_d = IDLE;
      default:                            state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and timer controls.
  always_comb begin
    k_d      = k_q;
    p_d      = p_q;
    upd_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sh_load  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = sh_dwell;
    tmr_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          sh_load  = 1'b1;
          k_d      = bus.cfg_k_start;
          p_d      = bus.cfg_phase;
          upd_d    = 1'b1;
          busy_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = bus.cfg_dwell;
        end
      end
      DWELL: begin
        if (bus.abort) begin
          k_d    = '0;
          upd_d  = 1'b1;
          busy_d = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      STEP: begin
        if (bus.abort) begin
          k_d    = '0;
          upd_d  = 1'b1;
          busy_d = 1'b0;
        end else if (step_ok) begin
          k_d      = step_sum[KW-1:0];
          upd_d    = 1'b1;
          tmr_load = 1'b1;
        end else if (sh_mode == MODE_CONT) begin
          k_d      = sh_start;
          upd_d    = 1'b1;
          tmr_load = 1'b1;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  // Output and shadow-config registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q      <= '0;
      p_q      <= '0;
      upd_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sh_mode  <= MODE_SINGLE;
      sh_start <= '0;
      sh_stop  <= '0;
      sh_step  <= '0;
      sh_dwell <= '0;
    end else begin
      k_q    <= k_d;
      p_q    <= p_d;
      upd_q  <= upd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      if (sh_load) begin
        sh_mode  <= bus.cfg_mode;
        sh_start <= bus.cfg_k_start;
        sh_stop  <= bus.cfg_k_stop;
        sh_step  <= bus.cfg_k_step;
        sh_dwell <= bus.cfg_dwell;
      end
    end
  end

  assign bus.k_out     = k_q;
  assign bus.p_out     = p_q;
  assign bus.upd       = upd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: the driver pushes hand-computed
// output events (k, p, kind, cycles since previous event) and a negedge
// monitor pops and compares every upd/done event the DUT presents.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int EW = 1 + 8 + PW + KW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  dds_sweep_ctrl_if bus();

  dds_sweep_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int busy_ticks = 0;
  int last_cyc = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Expected event: kind (1 = done, 0 = upd), delta cycles (0 = don't care).
  task automatic exp_evt(input logic is_done, input int delta,
                         input logic [KW-1:0] k, input logic [PW-1:0] p);
    exp_q.push_back({is_done, 8'(delta), p, k});
  endtask

  task automatic set_cfg(input logic mode, input logic [KW-1:0] ks,
                         input logic [KW-1:0] kstop, input logic [KW-1:0] kstep,
                         input logic [DW-1:0] dw, input logic [PW-1:0] ph);
    bus.cfg_mode    = mode;
    bus.cfg_k_start = ks;
    bus.cfg_k_stop  = kstop;
    bus.cfg_k_step  = kstep;
    bus.cfg_dwell   = dw;
    bus.cfg_phase   = ph;
  endtask

  // Leaves the driver one time unit after the edge that samples start.
  task automatic pulse_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    check("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  task automatic expect_basic(input logic [PW-1:0] ph);
    exp_evt(1'b0, 0, 32'd100, ph);
    exp_evt(1'b0, 4, 32'd150, ph);
    exp_evt(1'b0, 4, 32'd200, ph);
    exp_evt(1'b0, 4, 32'd250, ph);
    exp_evt(1'b1, 4, 32'd250, ph);
  endtask

  // Monitor: compares every presented event against the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst) begin
      if (bus.busy) busy_ticks++;
      if (bus.upd && bus.done) check("upd_done_excl", 64'd1, 64'd0);
      if (bus.upd || bus.done) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_evt: upd=%0b done=%0b k=%0h (t=%0t)",
                   bus.upd, bus.done, bus.k_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("evt_kind", 64'(bus.done), 64'(e[EW-1]));
          check("evt_k", 64'(bus.k_out), 64'(e[KW-1:0]));
          check("evt_p", 64'(bus.p_out), 64'(e[KW+PW-1:KW]));
          if (e[EW-2:KW+PW] != 8'd0)
            check("evt_delta", 64'(cyc - last_cyc), 64'(e[EW-2:KW+PW]));
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // Driver.
  initial begin
    int b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(1'b0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_k", 64'(bus.k_out), 64'd0);
    check("rst_p", 64'(bus.p_out), 64'd0);
    check("rst_upd", 64'(bus.upd), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'(IDLE));
    rst = 1'b0;

    // Basic single sweep 100..250 step 50, dwell 2.
    set_cfg(1'b0, 32'd100, 32'd250, 32'd50, 16'd2, 11'h155);
    expect_basic(11'h155);
    b0 = busy_ticks;
    pulse_start();
    wait_idle(100);
    check("basic_busy_cycles", 64'(busy_ticks - b0), 64'd16);
    repeat (3) @(negedge clk);
    check("basic_k_hold", 64'(bus.k_out), 64'd250);
    check("basic_p", 64'(bus.p_out), 64'h155);
    check("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // Overflow guard: carry ends the sweep, no wrap.
    set_cfg(1'b0, 32'hFFFFFF00, 32'hFFFFFFFF, 32'h200, 16'd1, 11'h0AA);
    exp_evt(1'b0, 0, 32'hFFFFFF00, 11'h0AA);
    exp_evt(1'b1, 3, 32'hFFFFFF00, 11'h0AA);
    pulse_start();
    wait_idle(50);
    repeat (2) @(negedge clk);
    check("ovf_k_hold", 64'(bus.k_out), 64'hFFFFFF00);
    check("ovf_q_empty", 64'(exp_q.size()), 64'd0);

    // Continuous 10,20,30,10,20 then abort while at 20.
    set_cfg(1'b1, 32'd10, 32'd30, 32'd10, 16'd0, 11'd7);
    exp_evt(1'b0, 0, 32'd10, 11'd7);
    exp_evt(1'b0, 2, 32'd20, 11'd7);
    exp_evt(1'b0, 2, 32'd30, 11'd7);
    exp_evt(1'b0, 2, 32'd10, 11'd7);
    exp_evt(1'b0, 2, 32'd20, 11'd7);
    exp_evt(1'b0, 1, 32'd0, 11'd7);
    pulse_start();
    repeat (8) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_k", 64'(bus.k_out), 64'd0);
    check("abort_upd", 64'(bus.upd), 64'd1);
    check("abort_done", 64'(bus.done), 64'd0);
    repeat (3) @(negedge clk);
    check("cont_q_empty", 64'(exp_q.size()), 64'd0);

    // k_step = 0: single value held dwell+2 cycles.
    set_cfg(1'b0, 32'd7, 32'd100, 32'd0, 16'd3, 11'd3);
    exp_evt(1'b0, 0, 32'd7, 11'd3);
    exp_evt(1'b1, 5, 32'd7, 11'd3);
    pulse_start();
    wait_idle(50);
    repeat (2) @(negedge clk);
    check("step0_q_empty", 64'(exp_q.size()), 64'd0);

    // k_start > k_stop: single value then done.
    set_cfg(1'b0, 32'd500, 32'd100, 32'd1, 16'd0, 11'h7FF);
    exp_evt(1'b0, 0, 32'd500, 11'h7FF);
    exp_evt(1'b1, 2, 32'd500, 11'h7FF);
    pulse_start();
    wait_idle(50);
    repeat (2) @(negedge clk);
    check("inv_k_hold", 64'(bus.k_out), 64'd500);
    check("inv_q_empty", 64'(exp_q.size()), 64'd0);

    // Mid-sweep start and cfg changes are ignored.
    set_cfg(1'b0, 32'd100, 32'd250, 32'd50, 16'd2, 11'h0F0);
    expect_basic(11'h0F0);
    pulse_start();
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    set_cfg(1'b1, 32'd5, 32'd150, 32'd1, 16'd0, 11'h001);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle(100);
    repeat (3) @(negedge clk);
    check("ign_k_hold", 64'(bus.k_out), 64'd250);
    check("ign_q_empty", 64'(exp_q.size()), 64'd0);

    // start + abort together in IDLE: nothing starts.
    @(posedge clk);
    #1 begin bus.start = 1'b1; bus.abort = 1'b1; end
    @(posedge clk);
    #1 begin bus.start = 1'b0; bus.abort = 1'b0; end
    repeat (2) @(negedge clk);
    check("sa_busy", 64'(bus.busy), 64'd0);
    check("sa_state", 64'(bus.dbg_state), 64'(IDLE));
    check("sa_k", 64'(bus.k_out), 64'd250);

    // Asynchronous reset while k_out = 150.
    set_cfg(1'b0, 32'd100, 32'd250, 32'd50, 16'd2, 11'h155);
    exp_evt(1'b0, 0, 32'd100, 11'h155);
    pulse_start();
    repeat (4) @(posedge clk);
    #1 check("pre_rst_k", 64'(bus.k_out), 64'd150);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_k", 64'(bus.k_out), 64'd0);
    check("arst_p", 64'(bus.p_out), 64'd0);
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_upd", 64'(bus.upd), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fresh basic sweep after reset.
    expect_basic(11'h155);
    b0 = busy_ticks;
    pulse_start();
    wait_idle(100);
    check("rerun_busy_cycles", 64'(busy_ticks - b0), 64'd16);
    repeat (3) @(negedge clk);
    check("rerun_k_hold", 64'(bus.k_out), 64'd250);
    check("rerun_q_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
